// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_if
//  Description : Bundle of the two requester channels, the ALU port pair and
//                the shared response channel served by alu_arbiter.
//                slave  modport - arbiter side (takes requests, drives ALU and
//                                 response).
//                master modport - environment side (requesters, ALU, consumer).
//  Ports       : req0_* / req1_*   valid/ready request with A, B (32b), op (4b)
//                alu_a/b/op, alu_c  registered ALU operands out, result in
//                resp_*             valid/ready response with id, data, err
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [3:0]  req0_op;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [3:0]  req1_op;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_c;

  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_data;
  logic        resp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_c,
    output resp_valid, resp_id, resp_data, resp_err,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_c,
    input  resp_valid, resp_id, resp_data, resp_err,
    output resp_ready
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin sharing of one external 32-bit combinational ALU
//                between two valid/ready requesters. An accepted request is
//                latched into the ALU operand registers, evaluated for one
//                cycle, and returned on a single response channel tagged with
//                the requester id. One transaction in flight at a time.
//  Ports       : clk    - rising-edge clock
//                reset  - asynchronous active-low reset
//                bus    - alu_arbiter_if.slave (requests, ALU port, response)
//  Parameters  : RR_INIT - requester favoured after reset
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  // ALUOp encodings understood by the ALU
  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SLL  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_SLTU = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic        id_q, id_d;
  logic        err_q, err_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;
  logic        resp_valid_q, resp_valid_d;

  logic        grant_id;
  logic        accept;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [3:0]  sel_op;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLL, OP_SLTU: op_is_legal = 1'b1;
      default:                                                op_is_legal = 1'b0;
    endcase
  endfunction

  // Arbitration: a tie goes to prio_q, otherwise the only valid requester wins.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = prio_q;
    end else begin
      grant_id = bus.req1_valid;
    end
  end

  // Gating with reset keeps both readys low while reset is held, even though
  // the state register already reads IDLE.
  assign accept = reset && (state_q == ST_IDLE) && (bus.req0_valid || bus.req1_valid);

  assign bus.req0_ready = accept && !grant_id;
  assign bus.req1_ready = accept &&  grant_id;

  assign sel_a  = grant_id ? bus.req1_a  : bus.req0_a;
  assign sel_b  = grant_id ? bus.req1_b  : bus.req0_b;
  assign sel_op = grant_id ? bus.req1_op : bus.req0_op;

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    id_d         = id_q;
    err_d        = err_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    resp_valid_d = resp_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Operand registers only move here, so the ALU sees stable inputs
          // for the whole EXEC/RESP window.
          alu_a_d  = sel_a;
          alu_b_d  = sel_b;
          alu_op_d = sel_op;
          id_d     = grant_id;
          err_d    = !op_is_legal(sel_op);
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // alu_c is undefined for illegal ops; never forward it in that case.
        resp_data_d  = err_q ? 32'd0 : bus.alu_c;
        resp_err_d   = err_q;
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          prio_d       = ~id_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      prio_q       <= RR_INIT;
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
      alu_op_q     <= 4'd0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      id_q         <= id_d;
      err_q        <= err_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter. Provides the external
//                ALU, drives both requesters and the response consumer, and
//                compares responses, arbitration order and latency against a
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam bit RR_INIT = 1'b0;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SLL  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_SLTU = 4'h8;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        err;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  alu_arbiter_if bus();

  alu_arbiter #(.RR_INIT(RR_INIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External ALU; its output for unknown ops is deliberately non-zero.
  always_comb begin
    case (bus.alu_op)
      OP_AND:  bus.alu_c = bus.alu_a & bus.alu_b;
      OP_OR:   bus.alu_c = bus.alu_a | bus.alu_b;
      OP_ADD:  bus.alu_c = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_c = bus.alu_a - bus.alu_b;
      OP_SLT:  bus.alu_c = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      OP_SLTU: bus.alu_c = (bus.alu_a < bus.alu_b) ? 32'd1 : 32'd0;
      OP_SLL:  bus.alu_c = bus.alu_b << bus.alu_a[4:0];
      default: bus.alu_c = 32'hDEAD_BEEF;
    endcase
  end

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];
  bit   tb_prio     = RR_INIT;
  bit   outstanding = 0;
  int   acc_cyc     = 0;
  bit   prev_valid  = 0;
  bit   held        = 0;
  logic [34:0] held_val;
  bit   must_acc    = 0;
  bit   done        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference behaviour of one transaction, straight from the op table.
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] d,
                                    output logic e);
    e = 1'b0;
    d = 32'd0;
    if      (op == OP_AND)  d = a & b;
    else if (op == OP_OR)   d = a | b;
    else if (op == OP_ADD)  d = a + b;
    else if (op == OP_SUB)  d = a - b;
    else if (op == OP_SLT)  d = {31'd0, $signed(a) < $signed(b)};
    else if (op == OP_SLTU) d = {31'd0, a < b};
    else if (op == OP_SLL)  d = b << a[4:0];
    else                    e = 1'b1;
  endfunction

  function automatic logic [3:0] rand_op();
    logic [3:0] legal [7];
    logic [3:0] any;
    legal = '{OP_AND, OP_OR, OP_ADD, OP_SLL, OP_SUB, OP_SLT, OP_SLTU};
    any   = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) return any;
    return legal[$urandom_range(0, 6)];
  endfunction

  // Present one request (called at posedge+1) and hold it until accepted.
  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op);
    exp_t e;
    int   n;
    bit   ok;
    ref_model(op, a, b, e.data, e.err);
    e.id = id; e.a = a; e.b = b; e.op = op;
    if (id == 1'b0) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
    end
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = (id == 1'b0) ? bus.req0_ready : bus.req1_ready;
      n++;
    end
    if (ok) begin
      sb.push_back(e);
    end else begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: requester %0d never saw ready", id);
    end
    @(posedge clk);
    #1;
    if (id == 1'b0) bus.req0_valid = 1'b0;
    else            bus.req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((outstanding || sb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (outstanding || sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: outstanding=%0d queued=%0d", outstanding, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: arbitration, exclusivity, latency, stability and scoreboard.
  always @(negedge clk) begin
    logic r0, r1;
    exp_t e;
    if (!reset) begin
      prev_valid = 1'b0;
      held       = 1'b0;
      must_acc   = 1'b0;
    end else begin
      r0 = bus.req0_valid && bus.req0_ready;
      r1 = bus.req1_valid && bus.req1_ready;
      if (must_acc) begin
        check("accept_after_hs", r0 || r1, 1'b1);
        must_acc = 1'b0;
      end
      if (r0 || r1) begin
        check("dual_ready", r0 && r1, 1'b0);
        check("ready_while_busy", outstanding, 1'b0);
        if (bus.req0_valid && bus.req1_valid) check("rr_grant", r1, tb_prio);
        outstanding = 1'b1;
        acc_cyc     = cyc;
      end else if (outstanding && sb.size() != 0) begin
        check("alu_operands", {bus.alu_op, bus.alu_a, bus.alu_b},
              {sb[0].op, sb[0].a, sb[0].b});
      end
      if (bus.resp_valid && !prev_valid) check("latency", cyc, acc_cyc + 2);
      if (bus.resp_valid && !outstanding) check("spurious_resp", bus.resp_valid, 1'b0);
      if (held) begin
        check("resp_stable", {bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_data}, held_val);
        held = 1'b0;
      end
      if (bus.resp_valid) begin
        if (bus.resp_ready) begin
          if (sb.size() == 0) begin
            check("resp_without_req", 1'b1, sb.size() != 0);
          end else begin
            e = sb.pop_front();
            check("resp_id_err_data", {bus.resp_id, bus.resp_err, bus.resp_data},
                  {e.id, e.err, e.data});
            tb_prio = ~e.id;
          end
          outstanding = 1'b0;
          must_acc    = bus.req0_valid || bus.req1_valid;
        end else begin
          held     = 1'b1;
          held_val = {bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_data};
        end
      end
      prev_valid = bus.resp_valid;
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready0"},    bus.req0_ready, 1'b0);
    check({tag, "_ready1"},    bus.req1_ready, 1'b0);
    check({tag, "_resp_valid"}, bus.resp_valid, 1'b0);
    check({tag, "_resp_data"}, bus.resp_data, 32'd0);
    check({tag, "_resp_id"},   bus.resp_id, 1'b0);
    check({tag, "_resp_err"},  bus.resp_err, 1'b0);
    check({tag, "_alu_a"},     bus.alu_a, 32'd0);
    check({tag, "_alu_b"},     bus.alu_b, 32'd0);
    check({tag, "_alu_op"},    bus.alu_op, 4'd0);
  endtask

  task automatic rand_requester(input bit id, input int count);
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      issue(id, $urandom, $urandom, rand_op());
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.resp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd2; bus.req0_op = OP_ADD;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd3; bus.req1_b = 32'd4; bus.req1_op = OP_ADD;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single SUB from requester 0.
    bus.resp_ready = 1'b1;
    issue(1'b0, 32'd5, 32'd3, OP_SUB);
    wait_idle();

    // Both requesters continuously valid: grants must alternate.
    fork
      repeat (4) issue(1'b0, 32'd1, 32'd1, OP_ADD);
      repeat (4) issue(1'b1, 32'hF0, 32'h0F, OP_OR);
    join
    wait_idle();

    // Signed versus unsigned compare of the same operands.
    issue(1'b1, 32'hFFFF_FFFF, 32'd1, OP_SLT);
    issue(1'b1, 32'hFFFF_FFFF, 32'd1, OP_SLTU);
    wait_idle();

    // Response backpressure with requester 1 waiting.
    bus.resp_ready = 1'b0;
    fork
      issue(1'b0, 32'd4, 32'd1, OP_SLL);
      begin
        @(posedge clk);
        #1;
        issue(1'b1, 32'd7, 32'd9, OP_ADD);
      end
      begin
        for (int i = 0; i < 20 && !bus.resp_valid; i++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
      end
    join
    wait_idle();

    // Illegal op.
    issue(1'b0, 32'h1234, 32'h5678, 4'hF);
    wait_idle();

    // Reset during EXEC discards the transaction and restores priority.
    issue(1'b0, 32'd1, 32'd2, OP_ADD);
    wait_idle();
    issue(1'b0, 32'd9, 32'd9, OP_AND);
    reset = 1'b0;
    sb.delete();
    outstanding = 1'b0;
    tb_prio     = RR_INIT;
    #1;
    check_zero_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    fork
      issue(1'b0, 32'd3, 32'd4, OP_ADD);
      issue(1'b1, 32'd3, 32'd4, OP_SUB);
    join
    wait_idle();

    // Randomized traffic with random response backpressure.
    fork
      begin
        fork
          rand_requester(1'b0, 30);
          rand_requester(1'b1, 30);
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.resp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.resp_ready = 1'b1;
    wait_idle();
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
